// File: rtl/garbage_sender_pkg.sv
// Shared definitions for the outbound garbage link: game FSM state codes,
// sender FSM states, attack tables and LFSR constants.
package garbage_sender_pkg;

  // Game FSM state codes observed on the state input.
  localparam logic [2:0] NOTH = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] DROP = 3'd2;
  localparam logic [2:0] LKDY = 3'd3;
  localparam logic [2:0] PLAC = 3'd4;
  localparam logic [2:0] ELIM = 3'd5;
  localparam logic [2:0] GARB = 3'd6;
  localparam logic [2:0] LOSE = 3'd7;

  localparam int         MAXROWS_DEF = 20;
  localparam logic [7:0] LFSR_SEED   = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_CALC   = 3'd2,
    S_CANCEL = 3'd3,
    S_SEND   = 3'd4
  } sender_state_e;

  // Base attack for 0..4 cleared rows: 0/0/1/2/4.
  function automatic logic [2:0] attack_base(input logic [2:0] lines);
    case (lines)
      3'd2:    attack_base = 3'd1;
      3'd3:    attack_base = 3'd2;
      3'd4:    attack_base = 3'd4;
      default: attack_base = 3'd0;
    endcase
  endfunction

  // Combo bonus from the pre-update combo count: 0-1 -> 0, 2-3 -> 1, 4-5 -> 2, 6+ -> 3.
  function automatic logic [1:0] combo_bonus(input logic [3:0] combo);
    if (combo >= 4'd6)      combo_bonus = 2'd3;
    else if (combo >= 4'd4) combo_bonus = 2'd2;
    else if (combo >= 4'd2) combo_bonus = 2'd1;
    else                    combo_bonus = 2'd0;
  endfunction

endpackage

// File: rtl/garbage_sender_if.sv
// Cross-board garbage packet link.
// Handshake: the master raises tx_valid with tx_rows/tx_hole and holds them
// stable until a cycle where tx_valid && tx_ready is sampled at posedge clk;
// that cycle transfers exactly one packet. tx_ready may change freely and
// does not depend on tx_valid. The master may withdraw an unaccepted packet
// only on a new piece placement, a game abort, or reset.
interface garbage_sender_if;
  logic       tx_valid;
  logic [4:0] tx_rows;
  logic [3:0] tx_hole;
  logic       tx_ready;

  modport master (output tx_valid, output tx_rows, output tx_hole, input tx_ready);
  modport slave  (input tx_valid, input tx_rows, input tx_hole, output tx_ready);
endinterface

// File: rtl/garbage_sender_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) mapped to a hole column.
module garbage_lfsr
  import garbage_sender_pkg::*;
#(
  parameter int COLS = 10
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] hole
);

  localparam logic [4:0] COLS_W = 5'(COLS);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic [3:0] h;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign h      = lfsr_q[3:0];
  // Nibbles past the board edge fold back by 6 so every value lands on a column.
  assign hole   = ({1'b0, h} < COLS_W) ? h : (h - 4'd6);

  // Advance the sequence every cycle; reset restarts from the fixed seed.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/garbage_sender.sv
// Outbound garbage sender: counts rows cleared per piece, converts them into
// an attack with combo/back-to-back bonuses, cancels against incoming garbage
// and offers the remainder to the opponent as a packet.
module garbage_sender
  import garbage_sender_pkg::*;
#(
  parameter int COLS    = 10,
  parameter int MAXROWS = MAXROWS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              state,
  input  logic                    row_full,
  input  logic [4:0]              incoming,
  output logic                    cancel_valid,
  output logic [4:0]              cancel_amt,
  garbage_sender_if.master        link,
  output logic [3:0]              combo,
  output logic                    drop_pulse,
  output sender_state_e           dbg_state
);

  localparam logic [4:0] MAX_W = 5'(MAXROWS);

  sender_state_e fsm_q;
  logic [2:0]    lines_q;
  logic [3:0]    combo_q;
  logic          b2b_q;
  logic [4:0]    attack_q;
  logic [3:0]    hole_q;
  logic          tx_valid_q;
  logic [4:0]    tx_rows_q;
  logic [3:0]    tx_hole_q;
  logic          cancel_valid_q;
  logic [4:0]    cancel_amt_q;
  logic          drop_pulse_q;

  logic [3:0]    lfsr_hole;
  logic [4:0]    atk_raw_d;
  logic [4:0]    atk_d;
  logic [4:0]    cancel_d;

  garbage_lfsr #(.COLS(COLS)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .hole (lfsr_hole)
  );

  // Attack for the piece just finished, saturated, and its cancel share.
  always_comb begin
    atk_raw_d = {2'b00, attack_base(lines_q)} + {3'b000, combo_bonus(combo_q)}
              + {4'b0000, (lines_q == 3'd4) && b2b_q};
    atk_d     = (atk_raw_d > MAX_W) ? MAX_W : atk_raw_d;
    cancel_d  = (atk_d < incoming) ? atk_d : incoming;
  end

  // Sender FSM with all outputs registered; a game abort overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q          <= S_IDLE;
      lines_q        <= 3'd0;
      combo_q        <= 4'd0;
      b2b_q          <= 1'b0;
      attack_q       <= 5'd0;
      hole_q         <= 4'd0;
      tx_valid_q     <= 1'b0;
      tx_rows_q      <= 5'd0;
      tx_hole_q      <= 4'd0;
      cancel_valid_q <= 1'b0;
      cancel_amt_q   <= 5'd0;
      drop_pulse_q   <= 1'b0;
    end else begin
      cancel_valid_q <= 1'b0;
      drop_pulse_q   <= 1'b0;
      if (state == NOTH) begin
        fsm_q        <= S_IDLE;
        combo_q      <= 4'd0;
        b2b_q        <= 1'b0;
        tx_valid_q   <= 1'b0;
        drop_pulse_q <= (fsm_q == S_SEND);
      end else begin
        case (fsm_q)
          S_IDLE: begin
            if (state == PLAC) begin
              lines_q <= 3'd0;
              fsm_q   <= S_COUNT;
            end
          end
          S_COUNT: begin
            if (state == ELIM) begin
              if (row_full && (lines_q < 3'd4)) lines_q <= lines_q + 3'd1;
            end else if (state != PLAC) begin
              fsm_q <= S_CALC;
            end
          end
          S_CALC: begin
            hole_q <= lfsr_hole;
            if (lines_q == 3'd0) begin
              combo_q <= 4'd0;
              fsm_q   <= S_IDLE;
            end else begin
              if (combo_q != 4'd15) combo_q <= combo_q + 4'd1;
              b2b_q <= (lines_q == 3'd4);
              if (atk_d == 5'd0) begin
                fsm_q <= S_IDLE;
              end else begin
                cancel_amt_q   <= cancel_d;
                cancel_valid_q <= (cancel_d != 5'd0);
                attack_q       <= atk_d - cancel_d;
                fsm_q          <= S_CANCEL;
              end
            end
          end
          S_CANCEL: begin
            if (attack_q == 5'd0) begin
              fsm_q <= S_IDLE;
            end else begin
              tx_valid_q <= 1'b1;
              tx_rows_q  <= attack_q;
              tx_hole_q  <= hole_q;
              fsm_q      <= S_SEND;
            end
          end
          S_SEND: begin
            if (tx_valid_q && link.tx_ready) begin
              // Accepted; a placement in the same cycle starts the next piece.
              tx_valid_q <= 1'b0;
              if (state == PLAC) begin
                lines_q <= 3'd0;
                fsm_q   <= S_COUNT;
              end else begin
                fsm_q <= S_IDLE;
              end
            end else if (state == PLAC) begin
              tx_valid_q   <= 1'b0;
              drop_pulse_q <= 1'b1;
              lines_q      <= 3'd0;
              fsm_q        <= S_COUNT;
            end
          end
          default: fsm_q <= S_IDLE;
        endcase
      end
    end
  end

  assign link.tx_valid = tx_valid_q;
  assign link.tx_rows  = tx_rows_q;
  assign link.tx_hole  = tx_hole_q;
  assign cancel_valid  = cancel_valid_q;
  assign cancel_amt    = cancel_amt_q;
  assign combo         = combo_q;
  assign drop_pulse    = drop_pulse_q;
  assign dbg_state     = fsm_q;

endmodule

// File: tb/tb_garbage_sender.sv
// Directed bench for garbage_sender with a reference attack/LFSR model and a
// packet scoreboard.
module tb_garbage_sender;
  import garbage_sender_pkg::*;

  logic          clk;
  logic          rst;
  logic [2:0]    state;
  logic          row_full;
  logic [4:0]    incoming;
  logic          cancel_valid;
  logic [4:0]    cancel_amt;
  logic [3:0]    combo;
  logic          drop_pulse;
  sender_state_e dbg_state;

  garbage_sender_if link ();

  garbage_sender #(.COLS(10), .MAXROWS(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .row_full     (row_full),
    .incoming     (incoming),
    .cancel_valid (cancel_valid),
    .cancel_amt   (cancel_amt),
    .link         (link.master),
    .combo        (combo),
    .drop_pulse   (drop_pulse),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard entries: {rows[4:0], hole[3:0]}.
  logic [8:0] exp_q[$];

  // Reference model state.
  logic [7:0] m_lfsr;
  int         m_combo;
  bit         m_b2b;

  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [3:0] model_hole(input logic [7:0] l);
    logic [3:0] h;
    h = l[3:0];
    model_hole = (h < 4'd10) ? h : (h - 4'd6);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // ---------------- packet monitor ----------------
  // Sampled just after the falling edge, once the drivers have settled.
  always @(negedge clk) begin
    #1;
    if (rst === 1'b0 && link.tx_valid === 1'b1 && link.tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pkt_unexpected", 32'({link.tx_rows, link.tx_hole}), 32'h1ff);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("pkt", 32'({link.tx_rows, link.tx_hole}), 32'(e));
      end
    end
  end

  // ---------------- driver ----------------
  // One piece: placement, n cleared rows in ELIM, then GARB. Checks the
  // CALC/CANCEL/SEND timing relative to the first GARB cycle (t0).
  task automatic piece(input int n, input int inc, input bit rdy, input bit noise);
    int lines, base, bonus, atk, canc, rem;
    logic [3:0] eh;
    @(negedge clk);
    link.tx_ready = rdy;
    incoming = 5'(inc);
    state = DROP; row_full = noise;
    @(negedge clk);
    state = PLAC; row_full = noise;
    @(negedge clk);
    state = ELIM; row_full = 1'b0;
    for (int i = 0; i < n; i++) begin
      row_full = 1'b1;
      @(negedge clk);
      row_full = 1'b0;
      @(negedge clk);
    end
    state = GARB;
    lines = (n > 4) ? 4 : n;
    base  = (lines == 4) ? 4 : (lines == 3) ? 2 : (lines == 2) ? 1 : 0;
    bonus = (m_combo >= 6) ? 3 : (m_combo >= 4) ? 2 : (m_combo >= 2) ? 1 : 0;
    if (lines == 0) begin
      m_combo = 0;
      atk = 0;
    end else begin
      atk = base + bonus + ((lines == 4 && m_b2b) ? 1 : 0);
      if (atk > 20) atk = 20;
      m_combo = (m_combo == 15) ? 15 : m_combo + 1;
      m_b2b = (lines == 4);
    end
    canc = (atk == 0) ? 0 : ((atk < inc) ? atk : inc);
    rem  = atk - canc;
    @(negedge clk);  // t1: CALC
    chk("calc_state", 32'(dbg_state), 32'(S_CALC));
    eh = model_hole(m_lfsr);
    if (rem > 0) exp_q.push_back({5'(rem), eh});
    @(negedge clk);  // t2: CANCEL, cancel pulse
    chk("cancel_valid", 32'(cancel_valid), 32'((atk > 0 && canc > 0) ? 1 : 0));
    if (atk > 0) chk("cancel_amt", 32'(cancel_amt), 32'(canc));
    @(negedge clk);  // t3: packet offered
    chk("tx_valid_t3", 32'(link.tx_valid), 32'((rem > 0) ? 1 : 0));
    if (rem > 0) begin
      chk("tx_rows_t3", 32'(link.tx_rows), 32'(rem));
      chk("tx_hole_t3", 32'(link.tx_hole), 32'(eh));
    end
    chk("combo", 32'(combo), 32'(m_combo));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_valid"},  32'(link.tx_valid), 32'd0);
    chk({tag, "_tx_rows"},   32'(link.tx_rows),  32'd0);
    chk({tag, "_tx_hole"},   32'(link.tx_hole),  32'd0);
    chk({tag, "_cancel_v"},  32'(cancel_valid),  32'd0);
    chk({tag, "_cancel_a"},  32'(cancel_amt),    32'd0);
    chk({tag, "_combo"},     32'(combo),         32'd0);
    chk({tag, "_drop"},      32'(drop_pulse),    32'd0);
    chk({tag, "_fsm"},       32'(dbg_state),     32'(S_IDLE));
    chk({tag, "_lfsr"},      32'(dut.u_lfsr.lfsr_q), 32'h0A5);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; state = NOTH; row_full = 1'b0; incoming = 5'd0;
    link.tx_ready = 1'b1;
    m_combo = 0; m_b2b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Two consecutive tetrises: 4 rows, then 4 + b2b = 5 rows.
    piece(4, 0, 1, 0);
    chk("tetris1_combo", 32'(combo), 32'd1);
    chk("tetris1_b2b", 32'(dut.b2b_q), 32'd1);
    piece(4, 0, 1, 0);
    chk("tetris2_combo", 32'(combo), 32'd2);

    // Zero-line piece breaks the combo; then seven doubles: 1,1,2,2,3,3,4.
    piece(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) piece(2, 0, 1, 0);
    chk("doubles_combo", 32'(combo), 32'd7);
    piece(0, 0, 1, 0);
    chk("zero_combo", 32'(combo), 32'd0);

    // Cancellation: tetris vs 3 incoming leaves 1 row.
    piece(4, 3, 1, 0);
    // Single with no bonus: attack 0, no cancel, no packet; clears b2b.
    piece(1, 0, 1, 0);
    piece(0, 0, 1, 0);
    // Tetris fully cancelled by 6 incoming.
    piece(4, 6, 1, 0);
    piece(0, 0, 1, 0);

    // Back-pressure: packet held stable for 10 cycles then accepted.
    piece(2, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(link.tx_valid), 32'd1);
      chk("hold_pkt", 32'({link.tx_rows, link.tx_hole}), 32'(exp_q[0]));
    end
    link.tx_ready = 1'b1;
    @(negedge clk);
    chk("accepted", 32'(link.tx_valid), 32'd0);
    chk("accepted_fsm", 32'(dbg_state), 32'(S_IDLE));

    // Placement while the packet waits: withdrawn with a drop pulse.
    piece(2, 0, 0, 0);
    state = PLAC;
    void'(exp_q.pop_back());
    @(negedge clk);
    state = DROP;
    chk("plac_drop_pulse", 32'(drop_pulse), 32'd1);
    chk("plac_tx_valid", 32'(link.tx_valid), 32'd0);
    chk("plac_fsm", 32'(dbg_state), 32'(S_COUNT));
    m_combo = 0;  // the re-entered piece clears no rows
    repeat (3) @(negedge clk);
    chk("plac_combo", 32'(combo), 32'd0);
    chk("plac_drop_done", 32'(drop_pulse), 32'd0);

    // Game abort while the packet waits.
    piece(4, 0, 0, 0);
    state = NOTH;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("noth_drop_pulse", 32'(drop_pulse), 32'd1);
    chk("noth_tx_valid", 32'(link.tx_valid), 32'd0);
    chk("noth_combo", 32'(combo), 32'd0);
    chk("noth_b2b", 32'(dut.b2b_q), 32'd0);
    chk("noth_fsm", 32'(dbg_state), 32'(S_IDLE));
    m_combo = 0; m_b2b = 1'b0;

    // Reset while the packet waits (with a partial cancel beforehand).
    piece(4, 1, 0, 0);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_send");
    m_combo = 0; m_b2b = 1'b0;

    // row_full outside ELIM must not count: still a double (1 row).
    piece(2, 0, 1, 1);
    row_full = 1'b0;
    state = DROP;
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
